// File: rtl/aes_byte_frontend.sv
// -----------------------------------------------------------------------------
// aes_byte_frontend
//
// Byte-serial front end for a single-block AES core. Thirty-two bytes are
// collected MSB-first: the first sixteen form the key, the next sixteen the
// plaintext. The block then pulses the core's reset/start for one cycle,
// releases it, and waits (bounded) for the core to finish. The ciphertext is
// registered and offered downstream with a valid/ready handshake. A core that
// never finishes raises a sticky error flag and the block returns to loading.
//
// Ports
//   clk         in   1    clock, rising edge
//   rst         in   1    asynchronous reset, active low
//   in_byte     in   8    serial input byte
//   in_valid    in   1    in_byte valid this cycle
//   in_ready    out  1    block accepts a byte this cycle (LOAD state)
//   core_key    out  128  key to the AES core
//   core_data   out  128  plaintext to the AES core
//   core_rst    out  1    active-high reset/start to the core, low only in RUN
//   core_ready  in   1    core done flag, held until the core is reset
//   core_out    in   128  core ciphertext, valid while core_ready=1
//   ct_data     out  128  registered ciphertext
//   ct_valid    out  1    ct_data valid
//   ct_ready    in   1    downstream accepts ct_data
//   err         out  1    sticky core-timeout flag
//
// Parameters
//   TIMEOUT_CYC  RUN cycles to wait for core_ready before giving up (16..65535)
// -----------------------------------------------------------------------------
module aes_byte_frontend #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_byte,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] core_key,
  output logic [127:0] core_data,
  output logic         core_rst,
  input  logic         core_ready,
  input  logic [127:0] core_out,
  output logic [127:0] ct_data,
  output logic         ct_valid,
  input  logic         ct_ready,
  output logic         err
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    KICK = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // The wait counter starts at 0 on the first RUN cycle, so the block gives up
  // on the edge that would move it to TIMEOUT_CYC: RUN lasts TIMEOUT_CYC cycles.
  localparam logic [15:0] LP_WAIT_LAST = 16'(TIMEOUT_CYC - 1);

  state_t         r_state;
  state_t         w_state_next;
  logic [4:0]     r_byte_cnt;
  logic [15:0]    r_wait_cnt;
  logic [127:0]   r_key;
  logic [127:0]   r_data;
  logic [127:0]   r_ct;
  logic           r_ct_valid;
  logic           r_err;

  logic           w_accept;
  logic           w_last_byte;
  logic           w_capture;
  logic           w_timeout;
  logic           w_handshake;

  assign w_accept    = in_valid && in_ready;
  assign w_last_byte = (r_byte_cnt == 5'd31);
  assign w_capture   = (r_state == RUN) && core_ready;
  assign w_timeout   = (r_state == RUN) && !core_ready && (r_wait_cnt == LP_WAIT_LAST);
  // DONE always has ct_valid set, so ct_ready only matters while a result is held.
  assign w_handshake = (r_state == DONE) && ct_ready;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of the order blocks are evaluated.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment first means every path drives w_state_next,
  // so no latch is inferred when a branch below forgets it.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      LOAD: if (w_accept && w_last_byte) w_state_next = KICK;
      KICK: w_state_next = RUN;
      RUN: begin
        if (core_ready) begin
          w_state_next = DONE;
        end else if (w_timeout) begin
          w_state_next = LOAD;
        end
      end
      DONE: if (ct_ready) w_state_next = LOAD;
      default: w_state_next = LOAD;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Byte collection: key then plaintext, shifted in MSB-first
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_byte_cnt <= '0;
      r_key      <= '0;
      r_data     <= '0;
    end else if (w_accept) begin
      // Counter wraps from 31 to 0 naturally; only accepted bytes advance it.
      r_byte_cnt <= r_byte_cnt + 5'd1;
      if (!r_byte_cnt[4]) begin
        r_key  <= {r_key[119:0], in_byte};
      end else begin
        r_data <= {r_data[119:0], in_byte};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Core wait counter: zero outside RUN, counts up while RUN waits
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wait_cnt <= '0;
    end else if (r_state == RUN && !core_ready && !w_timeout) begin
      r_wait_cnt <= r_wait_cnt + 16'd1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Result register, handshake and sticky error
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ct       <= '0;
      r_ct_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_capture) begin
        r_ct       <= core_out;
        r_ct_valid <= 1'b1;
      end else if (w_handshake) begin
        r_ct_valid <= 1'b0;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Gating with rst keeps in_ready low while reset is held, even though the
  // state register already reads LOAD.
  assign in_ready  = (r_state == LOAD) && rst;
  assign core_rst  = (r_state != RUN);
  assign core_key  = r_key;
  assign core_data = r_data;
  assign ct_data   = r_ct;
  assign ct_valid  = r_ct_valid;
  assign err       = r_err;

endmodule
